// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: FSM encoding, requester ids
// and default geometry.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_ST = 2'd1,
    ACK     = 2'd2
  } state_e;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

endpackage

// File: rtl/mem_array.sv
// Single-port storage: synchronous write, registered read with read enable.
// The storage itself is never reset; only the read register is.
module mem_array
  import mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] rdata_r;

  // storage write port; contents deliberately survive reset
  always_ff @(posedge clock) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
  end

  // registered read, updated only when a read is launched
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rdata_r <= '0;
    end else if (re) begin
      rdata_r <= mem_r[addr];
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/mem_responder.sv
// Memory responder serving an instruction-fetch port and a data port with
// fixed priority (data first), a fixed number of wait states per access and
// a saturating stall counter.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int WAIT   = 2
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              busy,
  output logic [15:0]       stall_count
);

  localparam logic [3:0] WAIT_C = 4'(WAIT);

  state_e            state_r, state_s;
  logic              port_r, we_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [3:0]        cnt_r;
  logic              i_ack_r, d_ack_r, busy_r;
  logic [DATA_W-1:0] i_hold_r, d_hold_r;
  logic [15:0]       stall_r;

  logic              accept_s, win_port_s, win_we_s;
  logic [ADDR_W-1:0] win_addr_s, arr_addr_s;
  logic              nxt_port_s, nxt_we_s;
  logic              arr_re_s, arr_we_s;
  logic [DATA_W-1:0] arr_rdata_s;
  logic              stall_s, i_rd_ack_s, d_rd_ack_s;

  // arbitration: data port wins over instruction port
  always_comb begin
    win_port_s = PORT_I;
    win_we_s   = 1'b0;
    win_addr_s = i_addr;
    if (d_req) begin
      win_port_s = PORT_D;
      win_we_s   = d_we;
      win_addr_s = d_addr;
    end else begin
      win_port_s = PORT_I;
      win_we_s   = 1'b0;
      win_addr_s = i_addr;
    end
    accept_s = (state_r == IDLE) && (i_req || d_req);
  end

  // FSM state register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = (WAIT_C == 4'd0) ? ACK : WAIT_ST;
        end else begin
          state_s = IDLE;
        end
      end
      WAIT_ST: begin
        if (cnt_r <= 4'd1) begin
          state_s = ACK;
        end else begin
          state_s = WAIT_ST;
        end
      end
      ACK:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // array control: the read is launched on the edge entering ACK so data is
  // valid during the ack cycle; the write commits on the edge leaving ACK
  always_comb begin
    nxt_port_s = port_r;
    nxt_we_s   = we_r;
    arr_addr_s = addr_r;
    if (state_r == IDLE) begin
      nxt_port_s = win_port_s;
      nxt_we_s   = win_we_s;
      arr_addr_s = win_addr_s;
    end else begin
      nxt_port_s = port_r;
      nxt_we_s   = we_r;
      arr_addr_s = addr_r;
    end
    arr_re_s = (state_s == ACK) && !nxt_we_s;
    arr_we_s = (state_r == ACK) && we_r;
  end

  // latch the accepted request and run the wait-state counter
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      port_r  <= PORT_I;
      we_r    <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
      cnt_r   <= 4'd0;
    end else if (accept_s) begin
      port_r  <= win_port_s;
      we_r    <= win_we_s;
      addr_r  <= win_addr_s;
      wdata_r <= d_req ? d_wdata : wdata_r;
      cnt_r   <= WAIT_C;
    end else if (state_r == WAIT_ST) begin
      cnt_r   <= cnt_r - 4'd1;
    end else begin
      cnt_r   <= cnt_r;
    end
  end

  // registered acks and busy, computed from the next state
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      i_ack_r <= 1'b0;
      d_ack_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      i_ack_r <= (state_s == ACK) && (nxt_port_s == PORT_I);
      d_ack_r <= (state_s == ACK) && (nxt_port_s == PORT_D);
      busy_r  <= (state_s != IDLE);
    end
  end

  assign i_rd_ack_s = (state_r == ACK) && (port_r == PORT_I) && !we_r;
  assign d_rd_ack_s = (state_r == ACK) && (port_r == PORT_D) && !we_r;

  // per-port copies of read data so each rdata holds between its own acks
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      i_hold_r <= '0;
      d_hold_r <= '0;
    end else begin
      i_hold_r <= i_rd_ack_s ? arr_rdata_s : i_hold_r;
      d_hold_r <= d_rd_ack_s ? arr_rdata_s : d_hold_r;
    end
  end

  assign stall_s = (i_req && !i_ack_r) || (d_req && !d_ack_r);

  // saturating count of cycles with an unacknowledged request
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stall_r <= 16'd0;
    end else if (stall_s && (stall_r != 16'hFFFF)) begin
      stall_r <= stall_r + 16'd1;
    end else begin
      stall_r <= stall_r;
    end
  end

  mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clock  (clock),
    .resetn (resetn),
    .we     (arr_we_s),
    .re     (arr_re_s),
    .addr   (arr_addr_s),
    .wdata  (wdata_r),
    .rdata  (arr_rdata_s)
  );

  assign i_ack       = i_ack_r;
  assign d_ack       = d_ack_r;
  assign busy        = busy_r;
  assign stall_count = stall_r;
  assign i_rdata     = i_rd_ack_s ? arr_rdata_s : i_hold_r;
  assign d_rdata     = d_rd_ack_s ? arr_rdata_s : d_hold_r;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: three instances (WAIT=2, 0, 15),
// table-driven accesses with a scoreboard queue, plus hand-written sequences
// for arbitration, reset mid-access and stall-counter saturation.
module tb_mem_responder;

  logic clock = 1'b0;
  logic resetn;
  always #5 clock = ~clock;

  // instance A: WAIT=2
  logic a_i_req, a_d_req, a_d_we, a_i_ack, a_d_ack, a_busy;
  logic [7:0] a_i_addr, a_d_addr, a_d_wdata, a_i_rdata, a_d_rdata;
  logic [15:0] a_stall;
  // instance B: WAIT=0
  logic b_i_req, b_d_req, b_d_we, b_i_ack, b_d_ack, b_busy;
  logic [7:0] b_i_addr, b_d_addr, b_d_wdata, b_i_rdata, b_d_rdata;
  logic [15:0] b_stall;
  // instance C: WAIT=15
  logic c_i_req, c_d_req, c_d_we, c_i_ack, c_d_ack, c_busy;
  logic [7:0] c_i_addr, c_d_addr, c_d_wdata, c_i_rdata, c_d_rdata;
  logic [15:0] c_stall;

  mem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT(2)) dut_a (
    .clock(clock), .resetn(resetn),
    .i_req(a_i_req), .i_addr(a_i_addr), .i_ack(a_i_ack), .i_rdata(a_i_rdata),
    .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
    .d_ack(a_d_ack), .d_rdata(a_d_rdata), .busy(a_busy), .stall_count(a_stall));

  mem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT(0)) dut_b (
    .clock(clock), .resetn(resetn),
    .i_req(b_i_req), .i_addr(b_i_addr), .i_ack(b_i_ack), .i_rdata(b_i_rdata),
    .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_ack(b_d_ack), .d_rdata(b_d_rdata), .busy(b_busy), .stall_count(b_stall));

  mem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT(15)) dut_c (
    .clock(clock), .resetn(resetn),
    .i_req(c_i_req), .i_addr(c_i_addr), .i_ack(c_i_ack), .i_rdata(c_i_rdata),
    .d_req(c_d_req), .d_we(c_d_we), .d_addr(c_d_addr), .d_wdata(c_d_wdata),
    .d_ack(c_d_ack), .d_rdata(c_d_rdata), .busy(c_busy), .stall_count(c_stall));

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic       port;   // 0 = fetch, 1 = data
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic       port;
    logic       we;
    logic [7:0] rdata;
  } exp_t;

  vec_t vecs[10];
  exp_t sb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One access on instance A (WAIT=2): latency 3, busy 3 cycles, stall +3.
  task automatic access_a(input logic port, input logic we, input logic [7:0] addr,
                          input logic [7:0] wdata, input logic [7:0] exp_rdata);
    int   k;
    bit   seen;
    bit   other;
    int   busy_n;
    logic [15:0] st0;
    exp_t e;
    @(posedge clock); #1;
    st0 = a_stall;
    if (port) begin
      a_d_req = 1'b1; a_d_we = we; a_d_addr = addr; a_d_wdata = wdata;
    end else begin
      a_i_req = 1'b1; a_i_addr = addr;
    end
    sb_q.push_back('{port: port, we: we, rdata: exp_rdata});
    k = 0; seen = 1'b0; other = 1'b0; busy_n = 0;
    while (!seen && k < 40) begin
      @(posedge clock);
      k++;
      if (k == 1) begin
        #1;
        // pin changes after acceptance must be ignored
        a_i_addr = ~addr; a_d_addr = ~addr; a_d_wdata = ~wdata; a_d_we = ~we;
      end
      @(negedge clock);
      if (a_busy) busy_n++;
      if (port ? a_i_ack : a_d_ack) other = 1'b1;
      if (port ? a_d_ack : a_i_ack) seen = 1'b1;
    end
    e = sb_q.pop_front();
    if (!seen) begin
      chk("a_ack_timeout", 32'd0, 32'd1);
    end else begin
      chk("a_latency", 32'(k), 32'd3);
      chk("a_busy_cycles", 32'(busy_n), 32'd3);
      chk("a_stall_delta", 32'(a_stall - st0), 32'd3);
      if (!e.we) chk("a_rdata", 32'(e.port ? a_d_rdata : a_i_rdata), 32'(e.rdata));
    end
    chk("a_other_ack_low", 32'(other), 32'd0);
    @(posedge clock); #1;
    a_i_req = 1'b0; a_d_req = 1'b0;
  endtask

  // Drive instance B (WAIT=0) with optional fetch and data requests raised
  // together; each requester drops its req on the edge after its ack.
  task automatic run_b(input logic use_i, input logic use_d, input logic we,
                       input logic [7:0] addr, input logic [7:0] wdata,
                       output int i_k, output int d_k, output bit both,
                       output logic [7:0] i_data, output logic [7:0] d_data);
    bit i_seen, d_seen;
    i_k = 0; d_k = 0; both = 1'b0; i_seen = 1'b0; d_seen = 1'b0;
    i_data = 8'h00; d_data = 8'h00;
    @(posedge clock); #1;
    b_i_req = use_i; b_i_addr = addr;
    b_d_req = use_d; b_d_we = we; b_d_addr = addr; b_d_wdata = wdata;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clock); #1;
      if (d_seen) b_d_req = 1'b0;
      if (i_seen) b_i_req = 1'b0;
      @(negedge clock);
      if (b_i_ack && b_d_ack) both = 1'b1;
      if (b_d_ack && !d_seen) begin d_seen = 1'b1; d_k = k; d_data = b_d_rdata; end
      if (b_i_ack && !i_seen) begin i_seen = 1'b1; i_k = k; i_data = b_i_rdata; end
    end
    b_i_req = 1'b0; b_d_req = 1'b0;
  endtask

  initial begin
    int   i_k, d_k;
    bit   both;
    logic [7:0] i_data, d_data;
    logic [15:0] prev;
    bit   mono;
    int   acks;

    vecs[0] = '{port: 1'b1, we: 1'b1, addr: 8'h80, wdata: 8'h3C, exp_rdata: 8'h00};
    vecs[1] = '{port: 1'b1, we: 1'b0, addr: 8'h80, wdata: 8'h00, exp_rdata: 8'h3C};
    vecs[2] = '{port: 1'b1, we: 1'b1, addr: 8'hFF, wdata: 8'h5A, exp_rdata: 8'h00};
    vecs[3] = '{port: 1'b1, we: 1'b1, addr: 8'h00, wdata: 8'h11, exp_rdata: 8'h00};
    vecs[4] = '{port: 1'b1, we: 1'b0, addr: 8'hFF, wdata: 8'h00, exp_rdata: 8'h5A};
    vecs[5] = '{port: 1'b0, we: 1'b0, addr: 8'h00, wdata: 8'h00, exp_rdata: 8'h11};
    vecs[6] = '{port: 1'b0, we: 1'b0, addr: 8'h80, wdata: 8'h00, exp_rdata: 8'h3C};
    vecs[7] = '{port: 1'b1, we: 1'b1, addr: 8'h20, wdata: 8'h77, exp_rdata: 8'h00};
    vecs[8] = '{port: 1'b0, we: 1'b0, addr: 8'h20, wdata: 8'h00, exp_rdata: 8'h77};
    vecs[9] = '{port: 1'b1, we: 1'b0, addr: 8'h10, wdata: 8'h00, exp_rdata: 8'hA5};

    resetn = 1'b0;
    a_i_req = 1'b0; a_d_req = 1'b0; a_d_we = 1'b0; a_i_addr = 8'h00; a_d_addr = 8'h00; a_d_wdata = 8'h00;
    b_i_req = 1'b0; b_d_req = 1'b0; b_d_we = 1'b0; b_i_addr = 8'h00; b_d_addr = 8'h00; b_d_wdata = 8'h00;
    c_i_req = 1'b0; c_d_req = 1'b0; c_d_we = 1'b0; c_i_addr = 8'h00; c_d_addr = 8'h00; c_d_wdata = 8'h00;

    // reset values
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_i_ack", 32'(a_i_ack), 32'd0);
    chk("rst_d_ack", 32'(a_d_ack), 32'd0);
    chk("rst_i_rdata", 32'(a_i_rdata), 32'd0);
    chk("rst_d_rdata", 32'(a_d_rdata), 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_stall", 32'(a_stall), 32'd0);
    chk("rst_b_busy", 32'(b_busy), 32'd0);
    chk("rst_c_stall", 32'(c_stall), 32'd0);
    @(posedge clock); #1;
    resetn = 1'b1;

    // preload mem[0x10]=0xA5, then reset: storage must survive
    access_a(1'b1, 1'b1, 8'h10, 8'hA5, 8'h00);
    @(posedge clock); #1 resetn = 1'b0;
    @(posedge clock); #1 resetn = 1'b1;
    @(negedge clock);
    chk("stall_after_reset", 32'(a_stall), 32'd0);

    // fetch from reset: ack in cycle 3, rdata 0xA5, busy 3, stall 3
    access_a(1'b0, 1'b0, 8'h10, 8'h00, 8'hA5);

    // table of accesses on instance A
    for (int v = 0; v < 10; v++) begin
      access_a(vecs[v].port, vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].exp_rdata);
    end

    // reset during WAIT_ST of a write 0xFF -> 0x20: write dropped
    @(posedge clock); #1;
    a_d_req = 1'b1; a_d_we = 1'b1; a_d_addr = 8'h20; a_d_wdata = 8'hFF;
    @(posedge clock);
    @(negedge clock);
    chk("busy_in_wait", 32'(a_busy), 32'd1);
    #1 resetn = 1'b0;
    #1;
    chk("midrst_d_ack", 32'(a_d_ack), 32'd0);
    chk("midrst_i_ack", 32'(a_i_ack), 32'd0);
    chk("midrst_busy", 32'(a_busy), 32'd0);
    chk("midrst_d_rdata", 32'(a_d_rdata), 32'd0);
    a_d_req = 1'b0; a_d_we = 1'b0;
    @(posedge clock); #1 resetn = 1'b1;
    @(negedge clock);
    chk("after_rst_idle", 32'(a_busy), 32'd0);
    access_a(1'b1, 1'b0, 8'h20, 8'h00, 8'h77);

    // instance B (WAIT=0): preload, then simultaneous requests
    run_b(1'b0, 1'b1, 1'b1, 8'h05, 8'h42, i_k, d_k, both, i_data, d_data);
    chk("b_wr_ack_cycle", 32'(d_k), 32'd1);
    chk("b_wr_no_i_ack", 32'(i_k), 32'd0);
    run_b(1'b1, 1'b1, 1'b0, 8'h05, 8'h00, i_k, d_k, both, i_data, d_data);
    chk("b_d_ack_cycle", 32'(d_k), 32'd1);
    chk("b_i_ack_cycle", 32'(i_k), 32'd3);
    chk("b_never_both", 32'(both), 32'd0);
    chk("b_d_rdata", 32'(d_data), 32'h42);
    chk("b_i_rdata", 32'(i_data), 32'h42);

    // instance C (WAIT=15): back-to-back fetches until the counter saturates
    @(posedge clock); #1;
    c_i_req = 1'b1; c_i_addr = 8'h00;
    prev = c_stall; mono = 1'b1; acks = 0;
    for (int n = 0; n < 70000; n++) begin
      @(negedge clock);
      if (c_stall < prev) mono = 1'b0;
      if (c_i_ack) acks++;
      prev = c_stall;
    end
    chk("c_stall_saturated", 32'(c_stall), 32'h0000FFFF);
    chk("c_stall_no_wrap", 32'(mono), 32'd1);
    chk("c_acks_flowing", 32'(acks >= 4000), 32'd1);
    repeat (40) @(negedge clock);
    chk("c_stall_stays", 32'(c_stall), 32'h0000FFFF);
    c_i_req = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
